scan_mux_nxw: RTL and testbench

- Parametrised successor to the fixed 6×4-bit latched display mux.
- Snapshots NUM_CH channels of WIDTH bits on a latch strobe.
- Drives one channel at a time to a time-multiplexed display. Channel order comes from an internal dwell-timed scanner or a manual select.
- Optional leading-zero blanking. Registered, glitch-free outputs. Sits between the value/BCD generators and the segment decoder/digit drivers.

---
 rtl/scan_mux_pkg.sv | 11 +
 rtl/scan_mux_nxw_timer.sv | 59 +++++
 rtl/scan_mux_nxw.sv | 106 ++++++++++
 tb/tb_scan_mux_nxw.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared constants and helpers for the scan multiplexer and its scan timer.
package scan_mux_pkg;

    localparam int         BLANK_VAL_DEF = 10;
    localparam logic [7:0] INVALID_CODE  = 8'hFF;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_mux_nxw_timer.sv
// Dwell-timed channel scanner: holds each index for DWELL cycles, freezes on request.
module scan_timer
    import scan_mux_pkg::*;
#(
    parameter  int NUM_CH = 6,
    parameter  int DWELL  = 1024,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_freeze,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_wrap
);

    localparam int               CNT_W    = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;

    // wrap_q is high during the first cycle the index is back at 0
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (!i_freeze) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_idx  = idx_q;
    assign o_wrap = wrap_q;

endmodule

// File: rtl/scan_mux_nxw.sv
// Latched N-channel display multiplexer with auto/manual scan and leading-zero blanking.
module scan_mux_nxw
    import scan_mux_pkg::*;
#(
    parameter  int NUM_CH    = 6,
    parameter  int WIDTH     = 4,
    parameter  int DWELL     = 1024,
    parameter  int BLANK_VAL = BLANK_VAL_DEF,
    localparam int SEL_W     = clog2_min1(NUM_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    input  logic                    i_latch,
    input  logic                    i_auto,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_lz_blank,
    output logic [WIDTH-1:0]        o_out,
    output logic [SEL_W-1:0]        o_ch,
    output logic [NUM_CH-1:0]       o_en,
    output logic                    o_frame
);

    localparam logic [WIDTH-1:0] BLANK_W  = WIDTH'(BLANK_VAL);
    localparam logic [WIDTH-1:0] INV_W    = INVALID_CODE[WIDTH-1:0];
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);

    logic [WIDTH-1:0]  lat_q [NUM_CH];
    logic [NUM_CH-1:0] blank;
    logic [SEL_W-1:0]  scan_idx;
    logic              scan_wrap;

    logic [WIDTH-1:0]  out_q, out_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic              frame_q, frame_d;

    scan_timer #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_freeze (~i_auto),
        .o_idx    (scan_idx),
        .o_wrap   (scan_wrap)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_CH; k++) lat_q[k] <= BLANK_W;
        end else if (i_latch) begin
            for (int k = 0; k < NUM_CH; k++) lat_q[k] <= i_data[k*WIDTH +: WIDTH];
        end
    end

    // A channel is blanked when it and every more significant channel hold zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            zero_run = zero_run & (lat_q[k] == '0);
            if (k > 0) blank[k] = i_lz_blank & zero_run;
        end
    end

    always_comb begin
        logic [SEL_W-1:0] sel;
        sel     = i_auto ? scan_idx : i_sel;
        out_d   = BLANK_W;
        ch_d    = sel;
        en_d    = '0;
        frame_d = i_auto & scan_wrap;
        if ({1'b0, sel} >= NUM_CH_X) begin
            out_d = INV_W;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel == SEL_W'(k)) begin
                    en_d[k] = 1'b1;
                    out_d   = blank[k] ? BLANK_W : lat_q[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q   <= BLANK_W;
            ch_q    <= '0;
            en_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    assign o_out   = out_q;
    assign o_ch    = ch_q;
    assign o_en    = en_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_scan_mux_nxw.sv
// Scoreboard bench for scan_mux_nxw with a time-count reference model.
module tb_scan_mux_nxw;

    localparam int N  = 6;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int BV = 10;
    localparam int SW = 3;

    typedef struct {
        logic [W-1:0]  out;
        logic [SW-1:0] ch;
        logic [N-1:0]  en;
        logic          frame;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N*W-1:0] data = '0;
    logic          latch = 1'b0;
    logic          auto_m = 1'b1;
    logic [SW-1:0] sel = '0;
    logic          lz = 1'b0;
    logic [W-1:0]  o_out;
    logic [SW-1:0] o_ch;
    logic [N-1:0]  o_en;
    logic          o_frame;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   model_en = 0;
    exp_t q[$];

    // Reference model state: latched values and number of auto-mode edges since reset
    int   lat[N];
    int   t;
    bit   last_inc;

    scan_mux_nxw #(.NUM_CH(N), .WIDTH(W), .DWELL(D), .BLANK_VAL(BV)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_latch(latch),
        .i_auto(auto_m), .i_sel(sel), .i_lz_blank(lz),
        .o_out(o_out), .o_ch(o_ch), .o_en(o_en), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    function automatic bit is_blank(int k, bit lzb);
        if (!lzb || k == 0) return 0;
        for (int j = k; j < N; j++) if (lat[j] != 0) return 0;
        return 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) lat[k] = BV;
            t = 0;
            last_inc = 0;
            q.delete();
        end else if (model_en) begin
            exp_t e;
            int   s;
            s = auto_m ? (t / D) % N : int'(sel);
            e.ch    = SW'(s);
            e.frame = auto_m && last_inc && t > 0 && (t % (D * N)) == 0;
            if (s >= N) begin
                e.out = '1;
                e.en  = '0;
            end else begin
                e.en  = N'(1) << s;
                e.out = is_blank(s, lz) ? W'(BV) : W'(lat[s]);
            end
            q.push_back(e);
            if (latch) for (int k = 0; k < N; k++) lat[k] = int'(data[k*W +: W]);
            if (auto_m) t++;
            last_inc = auto_m;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            total_cnt++;
            if (o_out == W'(BV) && o_ch == '0 && o_en == '0 && o_frame == 1'b0) pass_cnt++;
            else $display("FAIL rst_out t=%0t out=%0d/%0d ch=%0d/0 en=%b/000000 frame=%b/0",
                          $time, o_out, BV, o_ch, o_en, o_frame);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total_cnt++;
            if (o_out === e.out && o_ch === e.ch && o_en === e.en && o_frame === e.frame) pass_cnt++;
            else $display("FAIL scan_out t=%0t out=%0d/%0d ch=%0d/%0d en=%b/%b frame=%b/%b",
                          $time, o_out, e.out, o_ch, e.ch, o_en, e.en, o_frame, e.frame);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic set_ch(input int vals[N]);
        for (int k = 0; k < N; k++) data[k*W +: W] = W'(vals[k]);
    endtask

    task automatic pulse_latch();
        latch = 1'b1;
        cyc(1);
        latch = 1'b0;
    endtask

    initial begin
        cyc(2);
        model_en = 1;
        auto_m = 1'b1;
        do_reset();
        cyc(3);

        set_ch('{0, 1, 2, 3, 4, 5});
        pulse_latch();
        cyc(60);

        set_ch('{9, 9, 9, 9, 9, 9});
        cyc(30);
        pulse_latch();
        cyc(12);

        set_ch('{0, 1, 2, 3, 4, 5});
        pulse_latch();
        cyc(5);
        auto_m = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = SW'((s + 3) % 8);
            cyc(3);
        end
        auto_m = 1'b1;
        cyc(30);

        lz = 1'b1;
        set_ch('{7, 0, 0, 1, 0, 0});
        pulse_latch();
        cyc(30);
        set_ch('{0, 0, 0, 0, 0, 0});
        pulse_latch();
        cyc(30);
        lz = 1'b0;

        set_ch('{1, 2, 3, 4, 5, 6});
        pulse_latch();
        for (int i = 0; i < 50 && o_ch != 3'd3; i++) cyc(1);
        do_reset();
        auto_m = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            cyc(2);
        end
        auto_m = 1'b1;
        cyc(30);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < N; k++)
                    data[k*W +: W] = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(0, 15));
            latch = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) auto_m = ~auto_m;
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc(1);
        end
        latch = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
